jtpinpon_colmix: RTL and testbench
==================================

// Module: jtpinpon_colmix
// PURPOSE
//  Final video stage: merges the 4-bit char layer pixel with the 4-bit object pixel,
//  resolves priority, looks up the 32x8 colour PROM and expands RGB 3-3-2 to 4-4-4.
//  Sits downstream of the char and object generators and drives the frame RGB output.
//  Blanking signals are delayed to match pixel latency.
// PARAMETERS
//  LAT      3     pipeline depth in pxl_cen ticks, fixed; blanking delay equals LAT
//  SIMFILE  ""    optional colour PROM preload for simulation
// PORTS
//  clk        in   1  48 MHz video clock
//  rst_n      in   1  asynchronous active-low reset
//  pxl_cen    in   1  pixel clock enable; all pipeline stages advance only on it
//  LHBL       in   1  horizontal blank, active low, aligned with char_pxl/obj_pxl
//  LVBL       in   1  vertical blank, active low, aligned with char_pxl/obj_pxl
//  char_pxl   in   4  char layer palette index
//  obj_pxl    in   4  object layer palette index; 0 = transparent
//  gfx_en     in   2  debug layer enables: [0] char, [1] obj
//  prog_addr  in   5  colour PROM download address
//  prog_data  in   8  colour PROM data {B[1:0],G[2:0],R[2:0]}
//  prog_en    in   1  PROM write strobe; one byte per clk while high
//  red        out  4  red component
//  green      out  4  green component
//  blue       out  4  blue component
//  LHBL_dly   out  1  LHBL delayed by LAT pxl_cen ticks
//  LVBL_dly   out  1  LVBL delayed by LAT pxl_cen ticks
// BEHAVIOUR
//  - Reset: red/green/blue=0, LHBL_dly=LVBL_dly=0, all pipeline regs cleared.
//    The PROM contents are not cleared.
//  - Masking: c = gfx_en[0] ? char_pxl : 0 and o = gfx_en[1] ? obj_pxl : 0.
//  - S1 (pxl_cen): idx <= (o!=0) ? {1'b1,o} : {1'b0,c}. Objects always win over chars.
//    Char index 0 is a real colour (PROM entry 0), not transparency.
//  - S2 (pxl_cen): raw <= prom[idx]. Registered read.
//  - S3 (pxl_cen): expand raw. R4={R3,R3[2]}, G4={G3,G3[2]}, B4={B2,B2}.
//    Output 0 on all three channels if the blank signal delayed by 2 ticks shows
//    blanking (either LHBL or LVBL low).
//  - Blank shift regs: 3 deep, advanced on pxl_cen, aligned so LHBL_dly/LVBL_dly
//    change on the same tick as the RGB they qualify.
//  - Total latency: input sampled on tick N appears on outputs after tick N+2 registers
//    (3 pxl_cen edges).
//  - Between pxl_cen pulses all outputs hold their value.
//  - prog_en: prom[prog_addr] <= prog_data on every clk edge, independent of pxl_cen.
//    A simultaneous read of the same address returns the old data; the new data is
//    visible from the next read.
//  - Reset mid-frame: the pipeline flushes to black/blank. Outputs need 3 ticks after
//    release before they are valid again.
// STRUCTURE
//  - Shared package: PROM address/data widths (5/8), bit-field offsets of R/G/B in a
//    PROM byte, LAT.
//  - Sub-module: jtframe_prom (dw=8, aw=5) holds the colour PROM. Priority logic,
//    expansion and the blank delay stay in this module.
// TESTING
//  - Reset check: hold rst_n=0 with pxl_cen running -> RGB=0 and LHBL_dly=LVBL_dly=0.
//    Release, then 3 ticks of LHBL=LVBL=1 -> LHBL_dly=LVBL_dly=1.
//  - Priority: load prom[0x03]=0xFF and prom[0x15]=0x00. char=3, obj=5 -> RGB=000.
//    char=3, obj=0 -> RGB=FFF, appearing exactly 3 pxl_cen ticks after the input.
//  - Expansion: prom[0x02]=0b10_101_011 with char=2, obj=0 -> red=0x6, green=0xB, blue=0xA.
//  - Blanking: LHBL low for 1 tick mid-line -> exactly one black output pixel, aligned
//    with LHBL_dly low. Same test for LVBL.
//  - gfx_en: gfx_en=2'b01 with obj=5, char=3 -> output is prom[0x03].
//    gfx_en=2'b00 -> output is prom[0x00].
//  - Download collision: write prom[7] while idx=7 is being read -> old value first,
//    new value on the next tick. pxl_cen held low -> outputs stay constant.

Source files
------------

// File: rtl/jtpinpon_colmix_pkg.sv
// -----------------------------------------------------------------------------
// jtpinpon_colmix_pkg
// Shared definitions for the final colour-mix stage:
//   - colour PROM geometry (32 entries x 8 bits)
//   - bit-field positions of R/G/B inside a PROM byte {B[1:0],G[2:0],R[2:0]}
//   - fixed pipeline latency in pixel-clock-enable ticks
//   - helpers for layer priority and 3-3-2 to 4-4-4 colour expansion
// -----------------------------------------------------------------------------
package jtpinpon_colmix_pkg;

    localparam int PROM_AW  = 5;
    localparam int PROM_DW  = 8;

    // Field offsets inside one PROM byte
    localparam int R_LSB    = 0;    // R[2:0]
    localparam int G_LSB    = 3;    // G[2:0]
    localparam int B_LSB    = 6;    // B[1:0]

    // Pixel pipeline depth: priority -> PROM read -> expansion
    localparam int PIPE_LAT = 3;

    typedef logic [PROM_AW-1:0] prom_addr_t;
    typedef logic [PROM_DW-1:0] prom_data_t;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb444_t;

    // Objects always win over chars; char index 0 is a real colour.
    // The upper PROM half holds object colours, the lower half char colours.
    function automatic prom_addr_t resolve_idx(input logic [3:0] c, input logic [3:0] o);
        return (o != 4'd0) ? {1'b1, o} : {1'b0, c};
    endfunction

    // Replicate the top bits into the new LSBs so full scale maps to 4'hF
    function automatic rgb444_t expand_rgb(input prom_data_t raw);
        logic [2:0] r3;
        logic [2:0] g3;
        logic [1:0] b2;
        rgb444_t    px;
        r3   = raw[R_LSB +: 3];
        g3   = raw[G_LSB +: 3];
        b2   = raw[B_LSB +: 2];
        px.r = {r3, r3[2]};
        px.g = {g3, g3[2]};
        px.b = {b2, b2};
        return px;
    endfunction

endpackage

// File: rtl/jtpinpon_colmix_if.sv
// -----------------------------------------------------------------------------
// jtpinpon_colmix_if
// Video bus of the colour-mix stage: layer pixels and blanking in, PROM
// download port in, RGB and delayed blanking out.
//   master : upstream video generators / PROM loader (drives pixels, reads RGB)
//   slave  : jtpinpon_colmix
// Signals:
//   LHBL, LVBL        blanking, active low, aligned with char_pxl/obj_pxl
//   char_pxl[3:0]     char layer palette index
//   obj_pxl[3:0]      object layer palette index, 0 = transparent
//   gfx_en[1:0]       debug layer enables: [0] char, [1] obj
//   prog_addr/data/en colour PROM download, one byte per clk while prog_en
//   red/green/blue    4-bit colour components
//   LHBL_dly/LVBL_dly blanking delayed to match the RGB outputs
// -----------------------------------------------------------------------------
interface jtpinpon_colmix_if;

    logic       LHBL;
    logic       LVBL;
    logic [3:0] char_pxl;
    logic [3:0] obj_pxl;
    logic [1:0] gfx_en;

    logic [4:0] prog_addr;
    logic [7:0] prog_data;
    logic       prog_en;

    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
    logic       LHBL_dly;
    logic       LVBL_dly;

    modport master (
        output LHBL, LVBL, char_pxl, obj_pxl, gfx_en,
        output prog_addr, prog_data, prog_en,
        input  red, green, blue, LHBL_dly, LVBL_dly
    );

    modport slave (
        input  LHBL, LVBL, char_pxl, obj_pxl, gfx_en,
        input  prog_addr, prog_data, prog_en,
        output red, green, blue, LHBL_dly, LVBL_dly
    );

endinterface

// File: rtl/jtframe_prom.sv
// -----------------------------------------------------------------------------
// jtframe_prom
// Small dual-port PROM image: one write port that runs every clk (download),
// one registered read port that advances only on cen.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (read register only;
//                the array contents survive reset)
//   cen          read clock enable
//   rd_addr      read address
//   q            registered read data
//   wr_addr/wr_data/we  write port, one word per clk while we is high
// A read and write of the same address on the same edge returns the old word;
// the new word is seen by the next read.
// -----------------------------------------------------------------------------
module jtframe_prom #(
    parameter int dw      = 8,
    parameter int aw      = 5,
    parameter     SIMFILE = ""
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cen,
    input  logic [aw-1:0] rd_addr,
    output logic [dw-1:0] q,
    input  logic [aw-1:0] wr_addr,
    input  logic [dw-1:0] wr_data,
    input  logic          we
);

    logic [dw-1:0] mem [2**aw];
    logic [dw-1:0] q_q;

    // Simulation flows that want a preloaded image load mem from SIMFILE
    // hierarchically; in hardware the image always arrives over the write port.
    if (SIMFILE != "") begin : g_simfile
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (cen) begin
            q_q <= mem[rd_addr];
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jtpinpon_colmix.sv
// -----------------------------------------------------------------------------
// jtpinpon_colmix
// Final video stage. Merges the char and object pixels, resolves priority,
// looks up the 32x8 colour PROM and expands RGB 3-3-2 to 4-4-4. Blanking is
// delayed by the same number of pixel ticks as the colour path.
// Ports:
//   clk      48 MHz video clock
//   rst_n    asynchronous active-low reset (PROM contents are kept)
//   pxl_cen  pixel clock enable; every pipeline stage advances only on it
//   vid      video bus (slave side), see jtpinpon_colmix_if
// Pipeline (one pxl_cen tick per stage):
//   S1 idx_q  <= priority-resolved PROM index
//   S2 raw    <= prom[idx_q]           (inside jtframe_prom)
//   S3 rgb_q  <= expand(raw), forced black while blanked
// -----------------------------------------------------------------------------
module jtpinpon_colmix
    import jtpinpon_colmix_pkg::*;
#(
    parameter int LAT     = PIPE_LAT,
    parameter     SIMFILE = ""
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pxl_cen,
    jtpinpon_colmix_if.slave   vid
);

    logic [3:0]     c_msk;
    logic [3:0]     o_msk;
    prom_addr_t     idx_d;
    prom_addr_t     idx_q;
    prom_data_t     raw_rd;
    rgb444_t        rgb_d;
    rgb444_t        rgb_q;
    logic [LAT-1:0] hbl_q;
    logic [LAT-1:0] vbl_q;
    logic           show;

    always_comb begin
        c_msk = vid.gfx_en[0] ? vid.char_pxl : 4'd0;
        o_msk = vid.gfx_en[1] ? vid.obj_pxl  : 4'd0;
        idx_d = resolve_idx(c_msk, o_msk);
        // Bit LAT-2 holds the blanking that travelled with the pixel now in
        // raw_rd, so gating here keeps colour and blank in step.
        show  = hbl_q[LAT-2] & vbl_q[LAT-2];
        rgb_d = show ? expand_rgb(raw_rd) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            rgb_q <= '0;
            hbl_q <= '0;
            vbl_q <= '0;
        end else if (pxl_cen) begin
            idx_q <= idx_d;
            rgb_q <= rgb_d;
            hbl_q <= {hbl_q[LAT-2:0], vid.LHBL};
            vbl_q <= {vbl_q[LAT-2:0], vid.LVBL};
        end
    end

    jtframe_prom #(
        .dw      (PROM_DW),
        .aw      (PROM_AW),
        .SIMFILE (SIMFILE)
    ) u_prom (
        .clk     (clk),
        .rst_n   (rst_n),
        .cen     (pxl_cen),
        .rd_addr (idx_q),
        .q       (raw_rd),
        .wr_addr (vid.prog_addr),
        .wr_data (vid.prog_data),
        .we      (vid.prog_en)
    );

    assign vid.red      = rgb_q.r;
    assign vid.green    = rgb_q.g;
    assign vid.blue     = rgb_q.b;
    assign vid.LHBL_dly = hbl_q[LAT-1];
    assign vid.LVBL_dly = vbl_q[LAT-1];

endmodule

// File: tb/tb_jtpinpon_colmix.sv
// -----------------------------------------------------------------------------
// tb_jtpinpon_colmix
// Directed bench for the colour-mix stage. A behavioural model tracks what the
// outputs must show after every clock; a compare process checks the DUT on
// every falling edge, and literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_jtpinpon_colmix;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic pxl_cen;

  jtpinpon_colmix_if vid();

  jtpinpon_colmix dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pxl_cen (pxl_cen),
    .vid     (vid)
  );

  always #5 clk = ~clk;

  // ---------------- model state ----------------
  logic [7:0]  mprom [32];
  logic [4:0]  pend_idx;
  logic        pend_hb, pend_vb;
  logic [11:0] res_rgb;
  logic        res_hb, res_vb;
  logic [11:0] exp_rgb;
  logic        exp_hd, exp_vd;

  int vectors     = 0;
  int miscompares = 0;
  bit started     = 1'b0;

  // 3-bit and 2-bit intensities scaled to 4-bit full range
  function automatic logic [11:0] colour_of(input logic [7:0] b);
    int r3, g3, b2;
    r3 = int'(b[2:0]);
    g3 = int'(b[5:3]);
    b2 = int'(b[7:6]);
    return {4'((r3 * 15 + 3) / 7), 4'((g3 * 15 + 3) / 7), 4'(b2 * 5)};
  endfunction

  function automatic logic [4:0] pick(input logic [1:0] en, input logic [3:0] ch, input logic [3:0] ob);
    int c, o;
    c = en[0] ? int'(ch) : 0;
    o = en[1] ? int'(ob) : 0;
    return (o != 0) ? 5'(16 + o) : 5'(c);
  endfunction

  task automatic model_reset();
    pend_idx = '0; pend_hb = 1'b0; pend_vb = 1'b0;
    res_rgb  = '0; res_hb  = 1'b0; res_vb  = 1'b0;
    exp_rgb  = '0; exp_hd  = 1'b0; exp_vd  = 1'b0;
  endtask

  // ---------------- driver ----------------
  // One clk cycle; model advances on the same edge the DUT samples.
  task automatic cyc(input bit cen);
    pxl_cen = cen;
    @(posedge clk);
    if (rst_n && cen) begin
      exp_rgb  = (res_hb && res_vb) ? res_rgb : 12'h000;
      exp_hd   = res_hb;
      exp_vd   = res_vb;
      res_rgb  = colour_of(mprom[pend_idx]);
      res_hb   = pend_hb;
      res_vb   = pend_vb;
      pend_idx = pick(vid.gfx_en, vid.char_pxl, vid.obj_pxl);
      pend_hb  = vid.LHBL;
      pend_vb  = vid.LVBL;
    end
    if (vid.prog_en) mprom[vid.prog_addr] = vid.prog_data;
    #2;
  endtask

  task automatic tick();
    cyc(1'b1);
    cyc(1'b0);
  endtask

  task automatic prog(input logic [4:0] a, input logic [7:0] d);
    vid.prog_addr = a;
    vid.prog_data = d;
    vid.prog_en   = 1'b1;
    cyc(1'b0);
    vid.prog_en   = 1'b0;
  endtask

  task automatic set_px(input logic [3:0] ch, input logic [3:0] ob);
    vid.char_pxl = ch;
    vid.obj_pxl  = ob;
  endtask

  function automatic logic [13:0] outs();
    return {vid.LHBL_dly, vid.LVBL_dly, vid.red, vid.green, vid.blue};
  endfunction

  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got {hd,vd,rgb}=%b,%b,%h want %b,%b,%h", name,
               act[13], act[12], act[11:0], want[13], want[12], want[11:0]);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (started) begin
      vectors++;
      if ({vid.red, vid.green, vid.blue} !== exp_rgb ||
          vid.LHBL_dly !== exp_hd || vid.LVBL_dly !== exp_vd) begin
        miscompares++;
        $display("FAIL cycle_cmp t=%0t: got rgb=%h hd=%b vd=%b want rgb=%h hd=%b vd=%b",
                 $time, {vid.red, vid.green, vid.blue}, vid.LHBL_dly, vid.LVBL_dly,
                 exp_rgb, exp_hd, exp_vd);
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct packed {
    logic [1:0] en;
    logic [3:0] ch;
    logic [3:0] ob;
    logic       hb;
    logic       vb;
  } vec_t;

  vec_t table_v [8];

  initial begin
    pxl_cen       = 1'b0;
    vid.LHBL      = 1'b0;
    vid.LVBL      = 1'b0;
    vid.char_pxl  = '0;
    vid.obj_pxl   = '0;
    vid.gfx_en    = 2'b11;
    vid.prog_addr = '0;
    vid.prog_data = '0;
    vid.prog_en   = 1'b0;
    for (int i = 0; i < 32; i++) mprom[i] = 8'h00;
    model_reset();

    #1 rst_n = 1'b0;
    started  = 1'b1;

    // Reset with pxl_cen running
    repeat (4) tick();
    chk("reset_out", outs(), {2'b00, 12'h000});

    // PROM download while still in reset (contents are not affected by reset)
    for (int i = 0; i < 32; i++) prog(5'(i), 8'((i * 37 + 11) & 255));
    prog(5'h03, 8'hFF);
    prog(5'h15, 8'h00);
    prog(5'h02, 8'hAB);
    prog(5'h00, 8'h5A);
    prog(5'h07, 8'h11);

    // Release: blanking needs 3 ticks to propagate
    rst_n    = 1'b1;
    vid.LHBL = 1'b1;
    vid.LVBL = 1'b1;
    tick(); tick();
    chk("release_2ticks", outs(), {2'b00, 12'h000});
    tick();
    chk("release_3ticks", outs(), {2'b11, 12'h465});

    // Priority and latency
    set_px(4'd3, 4'd5); tick();
    set_px(4'd3, 4'd0); tick();
    chk("prio_latency_n1", outs(), {2'b11, 12'h465});
    tick();
    chk("prio_obj_wins", outs(), {2'b11, 12'h000});
    tick();
    chk("prio_char", outs(), {2'b11, 12'hFFF});

    // Expansion
    set_px(4'd2, 4'd0); repeat (3) tick();
    chk("expand_AB", outs(), {2'b11, 12'h6BA});

    // Horizontal blank pulse
    set_px(4'd3, 4'd0); repeat (3) tick();
    vid.LHBL = 1'b0; tick();
    vid.LHBL = 1'b1; tick();
    chk("hblank_before", outs(), {2'b11, 12'hFFF});
    tick();
    chk("hblank_pixel", outs(), {2'b01, 12'h000});
    tick();
    chk("hblank_after", outs(), {2'b11, 12'hFFF});

    // Vertical blank pulse
    vid.LVBL = 1'b0; tick();
    vid.LVBL = 1'b1; tick(); tick();
    chk("vblank_pixel", outs(), {2'b10, 12'h000});
    tick();
    chk("vblank_after", outs(), {2'b11, 12'hFFF});

    // Layer enables
    vid.gfx_en = 2'b01; set_px(4'd3, 4'd5); repeat (3) tick();
    chk("gfx_en_01", outs(), {2'b11, 12'hFFF});
    vid.gfx_en = 2'b00; repeat (3) tick();
    chk("gfx_en_00", outs(), {2'b11, 12'h465});
    vid.gfx_en = 2'b11;

    // Download collision on address 7
    set_px(4'd7, 4'd0); repeat (3) tick();
    chk("coll_old_steady", outs(), {2'b11, 12'h240});
    vid.prog_addr = 5'h07;
    vid.prog_data = 8'hC7;
    vid.prog_en   = 1'b1;
    cyc(1'b1);
    vid.prog_en   = 1'b0;
    cyc(1'b0);
    tick();
    chk("coll_old_first", outs(), {2'b11, 12'h240});
    tick();
    chk("coll_new_next", outs(), {2'b11, 12'hF0F});

    // Hold: pxl_cen low while inputs wander
    for (int i = 0; i < 10; i++) begin
      set_px(4'(i), 4'(15 - i));
      vid.LHBL = i[0];
      vid.gfx_en = 2'(i);
      cyc(1'b0);
    end
    chk("hold_no_cen", outs(), {2'b11, 12'hF0F});
    vid.gfx_en = 2'b11;
    vid.LHBL   = 1'b1;

    // Directed sweep, checked by the compare process every cycle
    table_v[0] = '{en: 2'b11, ch: 4'hF, ob: 4'h0, hb: 1'b1, vb: 1'b1};
    table_v[1] = '{en: 2'b11, ch: 4'h0, ob: 4'hF, hb: 1'b1, vb: 1'b1};
    table_v[2] = '{en: 2'b10, ch: 4'h9, ob: 4'h0, hb: 1'b1, vb: 1'b1};
    table_v[3] = '{en: 2'b10, ch: 4'h9, ob: 4'h1, hb: 1'b1, vb: 1'b1};
    table_v[4] = '{en: 2'b11, ch: 4'hA, ob: 4'h0, hb: 1'b0, vb: 1'b1};
    table_v[5] = '{en: 2'b11, ch: 4'h5, ob: 4'h6, hb: 1'b1, vb: 1'b0};
    table_v[6] = '{en: 2'b01, ch: 4'hC, ob: 4'hC, hb: 1'b1, vb: 1'b1};
    table_v[7] = '{en: 2'b11, ch: 4'h1, ob: 4'h0, hb: 1'b0, vb: 1'b0};
    for (int i = 0; i < 8; i++) begin
      vid.gfx_en = table_v[i].en;
      set_px(table_v[i].ch, table_v[i].ob);
      vid.LHBL = table_v[i].hb;
      vid.LVBL = table_v[i].vb;
      tick();
    end
    vid.gfx_en = 2'b11; vid.LHBL = 1'b1; vid.LVBL = 1'b1;
    set_px(4'd2, 4'd0);
    repeat (3) tick();
    chk("sweep_settle", outs(), {2'b11, 12'h6BA});

    // Mid-frame reset: immediate black/blank, PROM retained after release
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset", outs(), {2'b00, 12'h000});
    repeat (2) tick();
    rst_n = 1'b1;
    tick(); tick();
    chk("rerelease_2ticks", outs(), {2'b00, 12'h000});
    tick();
    chk("rerelease_3ticks", outs(), {2'b11, 12'h6BA});

    repeat (2) tick();
    started = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
